// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared defaults, tag-width helper and response record for the ROM arbiter
package rom_arb_pkg;

   localparam int ADDR_W_DEF = 3;
   localparam int DATA_W_DEF = 4;

   // A single requester still needs a 1-bit tag, so clamp below 2.
   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int ID_W_DEF = id_w(2);

   typedef struct packed {
      logic                  valid;
      logic [ID_W_DEF-1:0]   id;
      logic [DATA_W_DEF-1:0] data;
   } rsp_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first request at or after ptr, wrapping
module rr_pick #(
   parameter int N_REQ = 2,
   parameter int ID_W  = 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  idx,
   output logic             any
);

   always_comb begin
      int k;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      k   = 0;
      for (int i = 0; i < N_REQ; i++) begin
         k = (int'(ptr) + i) % N_REQ;
         if (!any && req[k]) begin
            any    = 1'b1;
            gnt[k] = 1'b1;
            idx    = ID_W'(k);
         end
      end
   end

endmodule

// File: rtl/rom_rr_arbiter.sv
// rtl/rom_rr_arbiter.sv - round-robin sharing of one registered-read ROM; optional grant lock under ROM_ARB_LOCK_EN
module rom_rr_arbiter
   import rom_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int N_REQ  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   output logic [N_REQ-1:0]        gnt,
   output logic                    rom_en,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [DATA_W-1:0]       rom_data,
`ifdef ROM_ARB_LOCK_EN
   input  logic [N_REQ-1:0]        lock,
`endif
   output logic                    rsp_valid,
   output logic [id_w(N_REQ)-1:0]  rsp_id,
   output logic [DATA_W-1:0]       rsp_data
);

   localparam int ID_W = id_w(N_REQ);

   logic [ID_W-1:0]  ptr;
   logic [N_REQ-1:0] req_eff;
   logic [N_REQ-1:0] pick_gnt;
   logic [ID_W-1:0]  pick_idx;
   logic             pick_any;
   logic             grant_any;
   logic             hold;
   logic             s1_v;
   logic [ID_W-1:0]  s1_id;

`ifdef ROM_ARB_LOCK_EN
   logic            owner_v;
   logic [ID_W-1:0] owner_id;

   // Ownership lapses combinationally, so the release cycle already arbitrates normally.
   assign hold = owner_v && lock[owner_id] && req[owner_id];

   always_comb begin
      req_eff = req;
      if (hold) begin
         req_eff           = '0;
         req_eff[owner_id] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner_v  <= 1'b0;
         owner_id <= '0;
      end else if (grant_any && !hold) begin
         owner_v  <= lock[pick_idx];
         owner_id <= pick_idx;
      end else if (!hold) begin
         owner_v  <= 1'b0;
      end
   end
`else
   assign hold    = 1'b0;
   assign req_eff = req;
`endif

   rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
      .req (req_eff),
      .ptr (ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign grant_any = rst_n & pick_any;
   assign gnt       = rst_n ? pick_gnt : '0;
   assign rom_en    = grant_any;

   always_comb begin
      rom_addr = '0;
      if (grant_any)
         rom_addr = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr       <= '0;
         s1_v      <= 1'b0;
         s1_id     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         if (grant_any && !hold)
            ptr <= (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + ID_W'(1);
         s1_v      <= grant_any;
         s1_id     <= pick_idx;
         rsp_valid <= s1_v;
         rsp_id    <= s1_id;
         if (s1_v)
            rsp_data <= rom_data;
      end
   end

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// tb/tb_rom_rr_arbiter.sv - directed self-checking bench for rom_rr_arbiter with an 8x4 registered ROM model
module tb_rom_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [1:0] req;
   logic [5:0] req_addr;
   logic [1:0] gnt;
   logic       rom_en;
   logic [2:0] rom_addr;
   logic [3:0] rom_data;
   logic       rsp_valid;
   logic [0:0] rsp_id;
   logic [3:0] rsp_data;
`ifdef ROM_ARB_LOCK_EN
   logic [1:0] lock;
`endif

   logic [3:0] rom [8];
   logic [3:0] exp_d [8];
   int total;
   int bad;

   rom_rr_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_addr  (req_addr),
      .gnt       (gnt),
      .rom_en    (rom_en),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
`ifdef ROM_ARB_LOCK_EN
      .lock      (lock),
`endif
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk)
      if (rom_en) rom_data <= rom[rom_addr];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic do_reset;
      tick; rst_n = 1'b0; req = 2'b00;
      tick; rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; req = 2'b11; req_addr = {3'd7, 3'd5};
      for (int i = 0; i < 3; i++) begin
         tick; #1;
         total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt cyc%0d got=%b want=00", i, gnt); end
         total++; if (rom_en !== 1'b0) begin bad++; $display("FAIL reset_rom_en cyc%0d got=%b want=0", i, rom_en); end
         total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid cyc%0d got=%b want=0", i, rsp_valid); end
      end
      total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
      total++; if (rsp_data !== 4'h0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
      tick; rst_n = 1'b1; req = 2'b00;
      #1;
      total++; if (rom_addr !== 3'd0) begin bad++; $display("FAIL idle_rom_addr got=%0d want=0", rom_addr); end
   endtask

   task automatic test_single;
      tick; req = 2'b01; req_addr = {3'd0, 3'd2}; #1;
      total++; if (gnt !== 2'b01) begin bad++; $display("FAIL single_gnt got=%b want=01", gnt); end
      total++; if (rom_en !== 1'b1 || rom_addr !== 3'd2) begin bad++; $display("FAIL single_rom got=%b/%0d want=1/2", rom_en, rom_addr); end
      tick; req = 2'b00; #1;
      total++; if (gnt !== 2'b00 || rsp_valid !== 1'b0) begin bad++; $display("FAIL single_t1 got=%b/%b want=00/0", gnt, rsp_valid); end
      tick; #1;
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 4'hA) begin
         bad++; $display("FAIL single_rsp got=%b/%0d/%h want=1/0/a", rsp_valid, rsp_id, rsp_data); end
      tick; #1;
      total++; if (rsp_valid !== 1'b0 || rsp_data !== 4'hA) begin bad++; $display("FAIL single_hold got=%b/%h want=0/a", rsp_valid, rsp_data); end
   endtask

   task automatic test_contention;
      logic [1:0] eg;
      logic [0:0] eid;
      logic [3:0] ed;
      do_reset;
      for (int i = 0; i < 7; i++) begin
         tick;
         req = (i < 4) ? 2'b11 : 2'b00;
         req_addr = {3'd7, 3'd5};
         #1;
         eg = (i >= 4) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
         total++; if (gnt !== eg) begin bad++; $display("FAIL cont_gnt cyc%0d got=%b want=%b", i, gnt, eg); end
         if (i >= 2 && i < 6) begin
            eid = ((i - 2) % 2 == 0) ? 1'b0 : 1'b1;
            ed  = (eid == 1'b0) ? 4'hD : 4'hB;
            total++; if (rsp_valid !== 1'b1 || rsp_id !== eid || rsp_data !== ed) begin
               bad++; $display("FAIL cont_rsp cyc%0d got=%b/%0d/%h want=1/%0d/%h", i, rsp_valid, rsp_id, rsp_data, eid, ed); end
         end
      end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL cont_tail got=%b want=0", rsp_valid); end
   endtask

   task automatic test_back_to_back;
      do_reset;
      for (int i = 0; i < 10; i++) begin
         tick;
         req = (i < 8) ? 2'b10 : 2'b00;
         req_addr = {3'(i), 3'd0};
         #1;
         if (i < 8) begin
            total++; if (gnt !== 2'b10 || rom_addr !== 3'(i)) begin
               bad++; $display("FAIL b2b_gnt cyc%0d got=%b/%0d want=10/%0d", i, gnt, rom_addr, i); end
         end
         if (i >= 2) begin
            total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== exp_d[i-2]) begin
               bad++; $display("FAIL b2b_rsp cyc%0d got=%b/%0d/%h want=1/1/%h", i, rsp_valid, rsp_id, rsp_data, exp_d[i-2]); end
         end
      end
      tick; #1;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail got=%b want=0", rsp_valid); end
   endtask

   task automatic test_reset_midflight;
      tick; req = 2'b01; req_addr = {3'd0, 3'd3}; #1;
      total++; if (gnt !== 2'b01) begin bad++; $display("FAIL mid_gnt got=%b want=01", gnt); end
      tick; rst_n = 1'b0; req = 2'b00; #1;
      total++; if (rom_en !== 1'b0) begin bad++; $display("FAIL mid_rom_en got=%b want=0", rom_en); end
      tick; rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rsp cyc%0d got=%b want=0", i, rsp_valid); end
         tick;
      end
   endtask

   task automatic test_drop_before_grant;
      do_reset;
      tick; req = 2'b11; req_addr = {3'd1, 3'd4}; #1;
      total++; if (gnt !== 2'b01) begin bad++; $display("FAIL drop_gnt0 got=%b want=01", gnt); end
      tick; req = 2'b00; #1;
      total++; if (gnt !== 2'b00) begin bad++; $display("FAIL drop_gnt1 got=%b want=00", gnt); end
      tick; #1;
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 4'h7) begin
         bad++; $display("FAIL drop_rsp0 got=%b/%0d/%h want=1/0/7", rsp_valid, rsp_id, rsp_data); end
      tick; #1;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL drop_rsp1 got=%b want=0", rsp_valid); end
   endtask

`ifdef ROM_ARB_LOCK_EN
   task automatic test_lock;
      do_reset;
      tick; req = 2'b11; lock = 2'b10; req_addr = {3'd1, 3'd0}; #1;
      total++; if (gnt !== 2'b01) begin bad++; $display("FAIL lock_first got=%b want=01", gnt); end
      for (int i = 0; i < 4; i++) begin
         tick; #1;
         total++; if (gnt !== 2'b10) begin bad++; $display("FAIL lock_hold cyc%0d got=%b want=10", i, gnt); end
      end
      tick; lock = 2'b00; #1;
      total++; if (gnt !== 2'b01) begin bad++; $display("FAIL lock_release got=%b want=01", gnt); end
      tick; req = 2'b00; #1;
      tick; tick;
   endtask
`endif

   initial begin
      rom[0] = 4'h1; rom[1] = 4'h3; rom[2] = 4'hA; rom[3] = 4'h6;
      rom[4] = 4'h7; rom[5] = 4'hD; rom[6] = 4'h9; rom[7] = 4'hB;
      exp_d[0] = 4'h1; exp_d[1] = 4'h3; exp_d[2] = 4'hA; exp_d[3] = 4'h6;
      exp_d[4] = 4'h7; exp_d[5] = 4'hD; exp_d[6] = 4'h9; exp_d[7] = 4'hB;
      rom_data = 4'h0;
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      req = 2'b00;
      req_addr = '0;
`ifdef ROM_ARB_LOCK_EN
      lock = 2'b00;
`endif
      test_reset;
      test_single;
      test_contention;
      test_back_to_back;
      test_reset_midflight;
      test_drop_before_grant;
`ifdef ROM_ARB_LOCK_EN
      test_lock;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
